// File: rtl/mips_dmem_bridge.sv
// Bridges the processor's single-cycle load/store port to a valid/ready data memory, with sized, extended accesses and a watchdog.
// Latency: a zero-wait store takes 2 stalled cycles then DONE; a zero-wait load takes 3 stalled cycles then DONE.
// Backpressure: m_* stay stable in REQ until m_ready; stall holds the processor until DONE; the watchdog aborts after MAX_WAIT cycles.
module mips_dmem_bridge #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int MAX_WAIT   = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_rd,
    input  logic              mem_wrt,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              stall,
    output logic              misalign,
    output logic              timeout,
    output logic              m_req,
    output logic              m_we,
    output logic [3:0]        m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [31:0]       m_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);
    localparam logic [1:0]  SZ_BYTE   = 2'b00;
    localparam logic [1:0]  SZ_HALF   = 2'b01;

    state_t      state, state_nxt;
    logic [15:0] wait_cnt;
    logic        req_any, aligned, start, wd_expire, leave_req;
    logic [3:0]  be_calc;
    logic [4:0]  shift_calc, shift_q;
    logic [31:0] wdata_calc, rd_lane, rd_ext;
    logic [1:0]  size_q;
    logic        sext_q, we_q;

    assign req_any = mem_rd | mem_wrt;

    // Reserved size 2'b11 falls into the word arm everywhere.
    always_comb begin
        case (size)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = ~addr[0];
            default: aligned = (addr[1:0] == 2'b00);
        endcase
    end

    // shift_calc is the right-shift that brings the addressed lane down to bit 0 on a read.
    always_comb begin
        be_calc    = 4'b1111;
        shift_calc = 5'd0;
        wdata_calc = din;
        case (size)
            SZ_BYTE: begin
                wdata_calc = {4{din[7:0]}};
                if (BIG_ENDIAN) begin
                    be_calc    = 4'b1000 >> addr[1:0];
                    shift_calc = 5'd24 - {addr[1:0], 3'b000};
                end else begin
                    be_calc    = 4'b0001 << addr[1:0];
                    shift_calc = {addr[1:0], 3'b000};
                end
            end
            SZ_HALF: begin
                wdata_calc = {2{din[15:0]}};
                if (BIG_ENDIAN) begin
                    be_calc    = addr[1] ? 4'b0011 : 4'b1100;
                    shift_calc = addr[1] ? 5'd0 : 5'd16;
                end else begin
                    be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                    shift_calc = addr[1] ? 5'd16 : 5'd0;
                end
            end
            default: ;
        endcase
    end

    assign start = (state == IDLE) & req_any & aligned;

    // A handshake completing in the last allowed cycle wins over the watchdog.
    assign wd_expire = (wait_cnt == WAIT_LAST) &
                       (((state == REQ) & ~m_ready) | ((state == WAIT_R) & ~m_rvalid));
    assign leave_req = (state == REQ) & (m_ready | wd_expire);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (m_ready) state_nxt = we_q ? DONE : WAIT_R;
                     else if (wd_expire) state_nxt = DONE;
            WAIT_R:  if (m_rvalid || wd_expire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // DONE releases the processor even though its request is still asserted.
    always_comb begin
        stall    = req_any & aligned & (state != DONE);
        misalign = (state == IDLE) & req_any & ~aligned;
        timeout  = wd_expire;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_be     <= 4'b0000;
            m_addr   <= '0;
            m_wdata  <= '0;
            size_q   <= 2'b00;
            shift_q  <= 5'd0;
            sext_q   <= 1'b0;
            we_q     <= 1'b0;
        end else if (start) begin
            wait_cnt <= '0;
            m_req    <= 1'b1;
            m_we     <= mem_wrt;
            m_be     <= be_calc;
            m_addr   <= {addr[ADDR_W-1:2], 2'b00};
            m_wdata  <= wdata_calc;
            size_q   <= size;
            shift_q  <= shift_calc;
            sext_q   <= sign_ext;
            we_q     <= mem_wrt;
        end else begin
            if (state == REQ || state == WAIT_R) wait_cnt <= wait_cnt + 16'd1;
            if (leave_req) begin
                m_req <= 1'b0;
                m_we  <= 1'b0;
                m_be  <= 4'b0000;
            end
        end
    end

    always_comb begin
        rd_lane = m_rdata >> shift_q;
        case (size_q)
            SZ_BYTE: rd_ext = {{24{sext_q & rd_lane[7]}}, rd_lane[7:0]};
            SZ_HALF: rd_ext = {{16{sext_q & rd_lane[15]}}, rd_lane[15:0]};
            default: rd_ext = rd_lane;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                          dout <= '0;
        else if (wd_expire)                  dout <= '0;
        else if (state == WAIT_R && m_rvalid) dout <= rd_ext;
    end
endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Bench for mips_dmem_bridge: big- and little-endian instances share stimulus, checked against a byte-addressed memory model.
module tb_mips_dmem_bridge;
    localparam int MAXW = 8;

    logic        clock, reset, mem_rd, mem_wrt, sign_ext, m_ready, m_rvalid;
    logic [31:0] addr, din, m_rdata;
    logic [1:0]  size;
    logic [31:0] dout_b, dout_l, m_addr_b, m_addr_l, m_wdata_b, m_wdata_l;
    logic        stall_b, stall_l, mis_b, mis_l, to_b, to_l;
    logic        m_req_b, m_req_l, m_we_b, m_we_l;
    logic [3:0]  m_be_b, m_be_l;

    int          n_chk, n_fail;
    logic [31:0] exp_dout_b, exp_dout_l;

    mips_dmem_bridge #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .MAX_WAIT(MAXW)) dut_b (
        .clock(clock), .reset(reset), .mem_rd(mem_rd), .mem_wrt(mem_wrt), .addr(addr),
        .size(size), .sign_ext(sign_ext), .din(din), .dout(dout_b), .stall(stall_b),
        .misalign(mis_b), .timeout(to_b), .m_req(m_req_b), .m_we(m_we_b), .m_be(m_be_b),
        .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_ready(m_ready), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata)
    );

    mips_dmem_bridge #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .MAX_WAIT(MAXW)) dut_l (
        .clock(clock), .reset(reset), .mem_rd(mem_rd), .mem_wrt(mem_wrt), .addr(addr),
        .size(size), .sign_ext(sign_ext), .din(din), .dout(dout_l), .stall(stall_l),
        .misalign(mis_l), .timeout(to_l), .m_req(m_req_l), .m_we(m_we_l), .m_be(m_be_l),
        .m_addr(m_addr_l), .m_wdata(m_wdata_l), .m_ready(m_ready), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: byte k of a word (address offset) lives on bit-lane 3-k (big) or k (little).
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic int lane(input int k, input bit big);
        return big ? 3 - k : k;
    endfunction

    function automatic bit is_aligned(input logic [31:0] a, input logic [1:0] sz);
        return (int'(a[1:0]) % nbytes(sz)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] sz, input bit big);
        logic [3:0] m;
        m = 4'b0000;
        for (int k = int'(a[1:0]); k < int'(a[1:0]) + nbytes(sz); k++) m[lane(k, big)] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] sz);
        case (nbytes(sz))
            1:       return {4{d[7:0]}};
            2:       return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [1:0] sz, input bit sx, input bit big);
        int n, o;
        logic [31:0] v;
        logic [7:0]  b;
        n = nbytes(sz);
        o = int'(a[1:0]);
        v = '0;
        for (int j = 0; j < n; j++) begin
            b = rd[8*lane(o + j, big) +: 8];
            if (big) v = (v << 8) | 32'(b);
            else     v = v | (32'(b) << (8 * j));
        end
        if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic check_douts(input string tag);
        check({tag, "_dout_b"}, dout_b, exp_dout_b);
        check({tag, "_dout_l"}, dout_l, exp_dout_l);
    endtask

    task automatic idle_cycle(input bit spurious);
        mem_rd = 1'b0; mem_wrt = 1'b0; m_ready = 1'b0;
        m_rvalid = spurious; m_rdata = $urandom;
        @(negedge clock);
        check("idle_stall", 32'({stall_b, stall_l}), 32'd0);
        check("idle_mreq", 32'({m_req_b, m_req_l, mis_b, mis_l, to_b, to_l}), 32'd0);
        check_douts("idle");
        @(posedge clock); #1;
        m_rvalid = 1'b0;
    endtask

    // Entered and left at 1 time unit after a rising edge, with both DUTs in IDLE.
    task automatic access(input bit wr, input bit both, input logic [31:0] a, input logic [1:0] sz,
                          input bit sx, input logic [31:0] d, input int rdy_dly, input int rv_dly,
                          input logic [31:0] rd, input bit junk_rv);
        int n, c;
        bit acc, got_rv, expired;
        mem_wrt = wr; mem_rd = !wr || both; addr = a; size = sz; sign_ext = sx; din = d;
        m_ready = 1'b0; m_rvalid = 1'b0;
        @(negedge clock);
        if (!is_aligned(a, sz)) begin
            check("misalign", 32'({mis_b, mis_l}), 32'd3);
            check("mis_stall", 32'({stall_b, stall_l}), 32'd0);
            check("mis_mreq", 32'({m_req_b, m_req_l}), 32'd0);
            check_douts("mis");
            @(posedge clock); #1;
            mem_rd = 1'b0; mem_wrt = 1'b0;
            @(negedge clock);
            check("mis_after", 32'({m_req_b, m_req_l, mis_b, mis_l}), 32'd0);
            check_douts("mis_after");
            @(posedge clock); #1;
            return;
        end
        check("req_stall", 32'({stall_b, stall_l}), 32'd3);
        check("req_idle", 32'({m_req_b, m_req_l, mis_b, mis_l}), 32'd0);
        @(posedge clock); #1;
        n = 0; c = 0; acc = 1'b0; got_rv = 1'b0; expired = 1'b0;
        while (!acc && !expired) begin
            n++;
            m_ready  = (c == rdy_dly);
            m_rvalid = junk_rv && m_ready;
            m_rdata  = $urandom;
            @(negedge clock);
            check("mreq", 32'({m_req_b, m_req_l}), 32'd3);
            check("m_we", 32'({m_we_b, m_we_l}), wr ? 32'd3 : 32'd0);
            check("m_addr_b", m_addr_b, a & 32'hFFFF_FFFC);
            check("m_addr_l", m_addr_l, a & 32'hFFFF_FFFC);
            check("m_be_b", 32'(m_be_b), 32'(exp_be(a, sz, 1'b1)));
            check("m_be_l", 32'(m_be_l), 32'(exp_be(a, sz, 1'b0)));
            if (wr) begin
                check("m_wdata_b", m_wdata_b, exp_wdata(d, sz));
                check("m_wdata_l", m_wdata_l, exp_wdata(d, sz));
            end
            expired = (n == MAXW) && !m_ready;
            check("timeout_req", 32'({to_b, to_l}), expired ? 32'd3 : 32'd0);
            check("stall_req", 32'({stall_b, stall_l}), 32'd3);
            acc = m_ready;
            c++;
            @(posedge clock); #1;
        end
        m_ready = 1'b0;
        c = 1;
        while (!wr && acc && !got_rv && !expired) begin
            n++;
            m_rvalid = (c == rv_dly);
            m_rdata  = m_rvalid ? rd : $urandom;
            @(negedge clock);
            check("wait_mreq", 32'({m_req_b, m_req_l, m_be_b, m_be_l}), 32'd0);
            check("wait_stall", 32'({stall_b, stall_l}), 32'd3);
            check_douts("wait");
            expired = (n == MAXW) && !m_rvalid;
            check("timeout_wait", 32'({to_b, to_l}), expired ? 32'd3 : 32'd0);
            got_rv = m_rvalid;
            c++;
            @(posedge clock); #1;
        end
        if (expired) begin
            exp_dout_b = '0;
            exp_dout_l = '0;
        end else if (!wr) begin
            exp_dout_b = exp_load(rd, a, sz, sx, 1'b1);
            exp_dout_l = exp_load(rd, a, sz, sx, 1'b0);
        end
        m_ready = 1'b0; m_rvalid = 1'($urandom_range(0, 1)); m_rdata = $urandom;
        @(negedge clock);
        check("done_stall", 32'({stall_b, stall_l}), 32'd0);
        check("done_idle", 32'({m_req_b, m_req_l, m_be_b, m_be_l, to_b, to_l}), 32'd0);
        check_douts("done");
        @(posedge clock); #1;
        m_rvalid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, dout_b | dout_l, 32'd0);
        check({tag, "_ctl"}, 32'({stall_b, stall_l, mis_b, mis_l, to_b, to_l,
                                  m_req_b, m_req_l, m_we_b, m_we_l}), 32'd0);
        check({tag, "_be"}, 32'({m_be_b, m_be_l}), 32'd0);
        check({tag, "_addr"}, m_addr_b | m_addr_l, 32'd0);
        check({tag, "_wdata"}, m_wdata_b | m_wdata_l, 32'd0);
    endtask

    initial begin
        bit          wr, both, sx, jr;
        logic [31:0] a, d, rd;
        logic [1:0]  sz;
        int          rdy, rv;
        n_chk = 0; n_fail = 0;
        exp_dout_b = '0; exp_dout_l = '0;
        reset = 1'b0; mem_rd = 1'b0; mem_wrt = 1'b0; addr = '0; size = 2'b00;
        sign_ext = 1'b0; din = '0; m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        access(1'b1, 1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, 1, 32'h0, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0013, 2'b00, 1'b1, 32'h0, 3, 1, 32'h1122_3380, 1'b0);
        check("byte_sx_b", dout_b, 32'hFFFF_FF80);
        access(1'b0, 1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'h0, 3, 1, 32'h1122_3380, 1'b1);
        check("byte_zx_b", dout_b, 32'h0000_0080);
        access(1'b1, 1'b1, 32'h0000_0022, 2'b01, 1'b0, 32'h0000_ABCD, 0, 1, 32'h0, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0006, 2'b10, 1'b0, 32'h0, 0, 1, 32'h0, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0008, 2'b10, 1'b0, 32'h0, -1, 1, 32'h0, 1'b0);
        check("timeout_dout", dout_b, 32'h0);
        access(1'b0, 1'b0, 32'h0000_0014, 2'b01, 1'b1, 32'h0, 0, 2, 32'h8001_7FFE, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0018, 2'b11, 1'b0, 32'h0, 1, -1, 32'h0, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0020, 2'b10, 1'b0, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b0);

        // Reset while a load sits in WAIT_R, then a stale read response after release.
        mem_rd = 1'b1; mem_wrt = 1'b0; addr = 32'h40; size = 2'b10; sign_ext = 1'b0; din = 32'h1234_5678;
        @(posedge clock); #1;
        m_ready = 1'b1;
        @(posedge clock); #1;
        m_ready = 1'b0; mem_rd = 1'b0;
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        exp_dout_b = '0; exp_dout_l = '0;
        @(negedge clock);
        reset = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h55;
        @(posedge clock); #1;
        @(negedge clock);
        check_all_zero("rst_late_rv");
        @(posedge clock); #1;
        m_rvalid = 1'b0;
        access(1'b1, 1'b0, 32'h0000_0030, 2'b00, 1'b0, 32'h0000_00A5, 0, 1, 32'h0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            wr   = 1'($urandom_range(0, 1));
            both = 1'($urandom_range(0, 1));
            sx   = 1'($urandom_range(0, 1));
            jr   = 1'($urandom_range(0, 1));
            a    = $urandom & 32'h0000_FFFF;
            sz   = 2'($urandom_range(0, 3));
            d    = $urandom;
            rd   = $urandom;
            rdy  = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 3));
            rv   = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(1, 3));
            access(wr, both, a, sz, sx, d, rdy, rv, rd, jr);
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
